// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } arb_state_t;

  // One data-memory access as presented to the memory port.
  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [2:0]             funct3;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - external loader/debug request and response channels
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int DM_ADDRESS = DMEM_ADDR_W
);

  logic                  ext_req_valid;
  logic                  ext_req_ready;
  logic                  ext_req_we;
  logic [DM_ADDRESS-1:0] ext_req_addr;
  logic [DATA_W-1:0]     ext_req_wdata;
  logic [2:0]            ext_req_funct3;
  logic                  ext_rsp_valid;
  logic                  ext_rsp_ready;
  logic [DATA_W-1:0]     ext_rsp_rdata;

  modport master (
    output ext_req_valid,
    input  ext_req_ready,
    output ext_req_we,
    output ext_req_addr,
    output ext_req_wdata,
    output ext_req_funct3,
    input  ext_rsp_valid,
    output ext_rsp_ready,
    input  ext_rsp_rdata
  );

  modport slave (
    input  ext_req_valid,
    output ext_req_ready,
    input  ext_req_we,
    input  ext_req_addr,
    input  ext_req_wdata,
    input  ext_req_funct3,
    output ext_rsp_valid,
    input  ext_rsp_ready,
    output ext_rsp_rdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of cycles the external requester was blocked
module arb_starve_ctr #(
  parameter  int LIMIT = 4,
  localparam int CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // With LIMIT = 0 the count never leaves zero, so at_limit is permanently set.
  assign at_limit = (cnt == LIM);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between the MEM stage and an external requester
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int DM_ADDRESS   = DMEM_ADDR_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  dmem_arbiter_if.slave         ext,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_t        state;
  logic [DATA_W-1:0] rsp_data;
  logic              cpu_acc;
  logic              ext_elig;
  logic              grant_ext;
  logic              at_limit;
  dmem_req_t         cpu_req;
  dmem_req_t         ext_req;
  dmem_req_t         mem_req;

  // Everything that reaches memory or the handshakes is qualified by reset.
  always_comb begin
    cpu_acc   = cpu_rd | cpu_wr;
    ext_elig  = reset & ext.ext_req_valid & (state == S_IDLE);
    grant_ext = ext_elig & (~cpu_acc | at_limit);

    cpu_req        = '0;
    cpu_req.rd     = cpu_rd;
    cpu_req.wr     = cpu_wr;
    cpu_req.addr   = cpu_addr;
    cpu_req.wdata  = cpu_wdata;
    cpu_req.funct3 = cpu_funct3;

    ext_req        = '0;
    ext_req.rd     = ~ext.ext_req_we;
    ext_req.wr     = ext.ext_req_we;
    ext_req.addr   = ext.ext_req_addr;
    ext_req.wdata  = ext.ext_req_wdata;
    ext_req.funct3 = ext.ext_req_funct3;

    mem_req = grant_ext ? ext_req : cpu_req;
  end

  assign mem_rd     = reset & mem_req.rd;
  assign mem_wr     = reset & mem_req.wr;
  assign mem_addr   = mem_req.addr;
  assign mem_wdata  = mem_req.wdata;
  assign mem_funct3 = mem_req.funct3;

  assign cpu_stall = cpu_acc & grant_ext;
  assign cpu_rdata = (reset & cpu_acc & ~grant_ext) ? mem_rdata : '0;

  assign ext.ext_req_ready = grant_ext;
  assign ext.ext_rsp_valid = reset & (state == S_RESP);
  assign ext.ext_rsp_rdata = rsp_data;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (ext_elig & ~grant_ext),
    .clr      (~ext.ext_req_valid | grant_ext),
    .at_limit (at_limit)
  );

  // A granted access is captured once; the response holds until taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      rsp_data <= '0;
    end else if (state == S_IDLE) begin
      if (grant_ext) begin
        state    <= S_RESP;
        rsp_data <= ext.ext_req_we ? '0 : mem_rdata;
      end
    end else if (ext.ext_rsp_ready) begin
      state <= S_IDLE;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a combinational memory model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic        cpu_rd, cpu_wr;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  logic        c0_rd, c0_wr;
  logic [8:0]  c0_addr;
  logic [31:0] c0_rdata;
  logic        c0_stall;
  logic        m0_rd, m0_wr;
  logic [8:0]  m0_addr;
  logic [31:0] m0_wdata;
  logic [2:0]  m0_funct3;
  logic [31:0] m0_rdata;

  logic [31:0] mem [0:127];
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) ext_if ();
  dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) ext0_if ();

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .STARVE_LIMIT(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_funct3 (cpu_funct3),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ext        (ext_if),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_funct3 (mem_funct3),
    .mem_rdata  (mem_rdata)
  );

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .STARVE_LIMIT(0)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (c0_rd),
    .cpu_wr     (c0_wr),
    .cpu_addr   (c0_addr),
    .cpu_wdata  (32'h0),
    .cpu_funct3 (3'b010),
    .cpu_rdata  (c0_rdata),
    .cpu_stall  (c0_stall),
    .ext        (ext0_if),
    .mem_rd     (m0_rd),
    .mem_wr     (m0_wr),
    .mem_addr   (m0_addr),
    .mem_wdata  (m0_wdata),
    .mem_funct3 (m0_funct3),
    .mem_rdata  (m0_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[8:2]];
  assign m0_rdata  = 32'h1234_5678;

  // Memory contents are (re)loaded while reset is low; location 0x020 is left to the test.
  always @(posedge clk) begin
    if (!reset) begin
      mem[4]  <= 32'hDEAD_BEEF;
      mem[16] <= 32'hCAFE_0001;
    end else if (mem_wr) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every accepted response must match the oldest issued request.
  always @(negedge clk) begin
    if (reset && ext_if.ext_rsp_valid && ext_if.ext_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got 0x%08h expected no response at %0t",
                 ext_if.ext_rsp_rdata, $time);
      end else begin
        chk("rsp_rdata", ext_if.ext_rsp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 9'h040; cpu_wdata = '0; cpu_funct3 = 3'b010;
    c0_rd = 1'b0; c0_wr = 1'b0; c0_addr = 9'h040;
    ext_if.ext_req_valid = 1'b1; ext_if.ext_req_we = 1'b0; ext_if.ext_req_addr = 9'h010;
    ext_if.ext_req_wdata = '0; ext_if.ext_req_funct3 = 3'b010; ext_if.ext_rsp_ready = 1'b0;
    ext0_if.ext_req_valid = 1'b0; ext0_if.ext_req_we = 1'b0; ext0_if.ext_req_addr = 9'h010;
    ext0_if.ext_req_wdata = '0; ext0_if.ext_req_funct3 = 3'b010; ext0_if.ext_rsp_ready = 1'b0;

    // Reset held with both sides requesting
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'(ext_if.ext_req_ready), 32'd0);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_rsp_valid", 32'(ext_if.ext_rsp_valid), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ext_if.ext_req_ready), 32'd0);
    chk("rel_stall", 32'(cpu_stall), 32'd0);
    chk("rel_mem_addr", 32'(mem_addr), 32'h040);
    chk("rel_cpu_rdata", cpu_rdata, 32'hCAFE_0001);
    next_cycle();
    ext_if.ext_req_valid = 1'b0; cpu_rd = 1'b0;
    @(negedge clk);
    chk("drop_ready", 32'(ext_if.ext_req_ready), 32'd0);
    next_cycle();

    // Idle CPU, ext read of 0x010
    ext_if.ext_req_valid = 1'b1; ext_if.ext_req_we = 1'b0; ext_if.ext_req_addr = 9'h010;
    exp_q.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("rd_ready", 32'(ext_if.ext_req_ready), 32'd1);
    chk("rd_mem_rd", 32'(mem_rd), 32'd1);
    chk("rd_mem_addr", 32'(mem_addr), 32'h010);
    chk("rd_rsp_valid0", 32'(ext_if.ext_rsp_valid), 32'd0);
    next_cycle();
    ext_if.ext_req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rd_rsp_valid", 32'(ext_if.ext_rsp_valid), 32'd1);
      chk("rd_rsp_hold", ext_if.ext_rsp_rdata, 32'hDEAD_BEEF);
      next_cycle();
    end
    ext_if.ext_rsp_ready = 1'b1;
    next_cycle();
    ext_if.ext_rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_rsp_done", 32'(ext_if.ext_rsp_valid), 32'd0);
    next_cycle();

    // CPU busy every cycle, ext write 0x55 to 0x020 waits out the starvation limit
    cpu_rd = 1'b1; cpu_addr = 9'h040;
    ext_if.ext_req_valid = 1'b1; ext_if.ext_req_we = 1'b1;
    ext_if.ext_req_addr = 9'h020; ext_if.ext_req_wdata = 32'h55;
    exp_q.push_back(32'h0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("blk_ready", 32'(ext_if.ext_req_ready), 32'd0);
      chk("blk_stall", 32'(cpu_stall), 32'd0);
      chk("blk_cpu_rdata", cpu_rdata, 32'hCAFE_0001);
      next_cycle();
    end
    @(negedge clk);
    chk("force_ready", 32'(ext_if.ext_req_ready), 32'd1);
    chk("force_stall", 32'(cpu_stall), 32'd1);
    chk("force_mem_wr", 32'(mem_wr), 32'd1);
    chk("force_mem_addr", 32'(mem_addr), 32'h020);
    chk("force_mem_wdata", mem_wdata, 32'h55);
    chk("force_cpu_rdata", cpu_rdata, 32'd0);
    next_cycle();
    ext_if.ext_req_valid = 1'b0; ext_if.ext_req_we = 1'b0;
    @(negedge clk);
    chk("resume_stall", 32'(cpu_stall), 32'd0);
    chk("resume_cpu_rdata", cpu_rdata, 32'hCAFE_0001);
    chk("resume_rsp_valid", 32'(ext_if.ext_rsp_valid), 32'd1);
    next_cycle();
    ext_if.ext_rsp_ready = 1'b1;
    next_cycle();
    ext_if.ext_rsp_ready = 1'b0;

    // Response back-pressured for 6 cycles while the next request waits
    cpu_rd = 1'b0;
    ext_if.ext_req_valid = 1'b1; ext_if.ext_req_we = 1'b0; ext_if.ext_req_addr = 9'h020;
    exp_q.push_back(32'h55);
    @(negedge clk);
    chk("bp_first_ready", 32'(ext_if.ext_req_ready), 32'd1);
    next_cycle();
    ext_if.ext_req_addr = 9'h010;
    exp_q.push_back(32'hDEAD_BEEF);
    cpu_rd = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("bp_ready", 32'(ext_if.ext_req_ready), 32'd0);
      chk("bp_stall", 32'(cpu_stall), 32'd0);
      chk("bp_rsp_valid", 32'(ext_if.ext_rsp_valid), 32'd1);
      chk("bp_rsp_hold", ext_if.ext_rsp_rdata, 32'h55);
      chk("bp_cpu_rdata", cpu_rdata, 32'hCAFE_0001);
      next_cycle();
    end
    ext_if.ext_rsp_ready = 1'b1; cpu_rd = 1'b0;
    @(negedge clk);
    chk("bp_accept_ready", 32'(ext_if.ext_req_ready), 32'd0);
    next_cycle();
    ext_if.ext_rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_ready", 32'(ext_if.ext_req_ready), 32'd1);
    chk("bp_next_addr", 32'(mem_addr), 32'h010);
    next_cycle();
    ext_if.ext_req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_rsp", ext_if.ext_rsp_rdata, 32'hDEAD_BEEF);
    next_cycle();
    ext_if.ext_rsp_ready = 1'b1;
    next_cycle();
    ext_if.ext_rsp_ready = 1'b0;

    // STARVE_LIMIT = 0 instance: ext wins on every eligible cycle
    c0_rd = 1'b1;
    ext0_if.ext_req_valid = 1'b1; ext0_if.ext_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("l0_ready", 32'(ext0_if.ext_req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("l0_stall", 32'(c0_stall), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("l0_rsp_valid", 32'(ext0_if.ext_rsp_valid), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("l0_cpu_rdata", c0_rdata, (i % 2 == 0) ? 32'd0 : 32'h1234_5678);
      if (i % 2 == 1) chk("l0_rsp_rdata", ext0_if.ext_rsp_rdata, 32'h1234_5678);
      next_cycle();
    end
    c0_rd = 1'b0; ext0_if.ext_req_valid = 1'b0; ext0_if.ext_rsp_ready = 1'b0;

    // Reset while a response is pending drops it
    ext_if.ext_req_valid = 1'b1; ext_if.ext_req_we = 1'b0; ext_if.ext_req_addr = 9'h010;
    @(negedge clk);
    chk("rr_ready", 32'(ext_if.ext_req_ready), 32'd1);
    next_cycle();
    ext_if.ext_req_valid = 1'b0;
    @(negedge clk);
    chk("rr_rsp_valid", 32'(ext_if.ext_rsp_valid), 32'd1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rr_in_reset", 32'(ext_if.ext_rsp_valid), 32'd0);
    next_cycle();
    reset = 1'b1; ext_if.ext_rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rr_after", 32'(ext_if.ext_rsp_valid), 32'd0);
      next_cycle();
    end
    ext_if.ext_rsp_ready = 1'b0;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
